// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scanner signal bundle: raw keypad lines plus the debounced key-code output.
interface keypad_scan_ctrl_if;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] scan_data;
    logic        valid;
    logic        key_held;

    modport master (
        input  key_row,
        output key_col,
        output scan_data,
        output valid,
        output key_held
    );

    modport slave (
        output key_row,
        input  key_col,
        input  scan_data,
        input  valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 3x4 keypad scanner: column-at-a-time drive, frame-level debounce FSM,
// one-hot key code with exactly one valid strobe per physical press.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input logic                  clk,
    input logic                  rst,
    keypad_scan_ctrl_if.master   kif
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REL_WAIT
    } state_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div_cnt;
    logic [2:0]    col_oh;
    logic [11:0]   acc, acc_nxt;
    logic [11:0]   frame;
    logic          frame_vld;
    logic          sample;

    state_t        state, state_nxt;
    logic [11:0]   cand, cand_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [11:0]   scan_q, scan_nxt;
    logic          valid_q, valid_nxt;
    logic          frame_empty, frame_single;

    assign sample = (div_cnt == DW'(SCAN_DIV - 1));

    // Merge the current column's synchronized rows into the accumulator image.
    always_comb begin
        acc_nxt = acc;
        for (int unsigned r = 0; r < 4; r++) begin
            if (col_oh[0]) acc_nxt[r*3]     = row_s2[r];
            if (col_oh[1]) acc_nxt[r*3 + 1] = row_s2[r];
            if (col_oh[2]) acc_nxt[r*3 + 2] = row_s2[r];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1    <= '0;
            row_s2    <= '0;
            div_cnt   <= '0;
            col_oh    <= 3'b001;
            acc       <= '0;
            frame     <= '0;
            frame_vld <= 1'b0;
        end else begin
            row_s1    <= kif.key_row;
            row_s2    <= row_s1;
            frame_vld <= sample && col_oh[2];
            if (sample) begin
                div_cnt <= '0;
                acc     <= acc_nxt;
                col_oh  <= {col_oh[1:0], col_oh[2]};
                if (col_oh[2]) frame <= acc_nxt;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    assign frame_empty  = (frame == '0);
    assign frame_single = !frame_empty && ((frame & (frame - 12'd1)) == '0);
    assign cnt_inc      = cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cand    <= '0;
            cnt     <= '0;
            scan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cand    <= cand_nxt;
            cnt     <= cnt_nxt;
            scan_q  <= scan_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        scan_nxt  = scan_q;
        valid_nxt = 1'b0;
        if (frame_vld) begin
            unique case (state)
                IDLE: begin
                    if (frame_single) begin
                        cand_nxt = frame;
                        cnt_nxt  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            scan_nxt  = frame;
                            valid_nxt = 1'b1;
                            state_nxt = PRESSED;
                        end else begin
                            state_nxt = PRESS_WAIT;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (frame == cand) begin
                        if (cnt_inc == CW'(DEBOUNCE)) begin
                            scan_nxt  = cand;
                            valid_nxt = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = PRESSED;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else if (frame_single) begin
                        cand_nxt = frame;
                        cnt_nxt  = CW'(1);
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
                PRESSED: begin
                    if (frame_empty) begin
                        if (DEBOUNCE == 1) begin
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt   = CW'(1);
                            state_nxt = REL_WAIT;
                        end
                    end
                end
                REL_WAIT: begin
                    if (frame_empty) begin
                        if (cnt_inc == CW'(DEBOUNCE)) begin
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = PRESSED;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign kif.key_col   = col_oh;
    assign kif.scan_data = scan_q;
    assign kif.valid     = valid_q;
    assign kif.key_held  = (state == PRESSED) || (state == REL_WAIT);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Keypad scanner bench: emulated keypad, frame-aligned stimulus and a
// run-length debounce reference model checked every cycle.
module tb_keypad_scan_ctrl;

    localparam int S   = 4;
    localparam int DEB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(.SCAN_DIV(S), .DEBOUNCE(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    logic [11:0] pressed = '0;

    // Physical keypad: a row line is high when a pressed key sits in the driven column.
    always_comb begin
        kif.key_row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (kif.key_col[c] && pressed[r*3 + c]) kif.key_row[r] = 1'b1;
    end

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Reference model: armed mode accepts after DEB identical single-key frames,
    // held mode re-arms after DEB consecutive empty frames.
    logic        m_held;
    int          m_run;
    int          m_empt;
    logic [11:0] m_key;
    logic        exp_valid;
    logic [11:0] exp_code;
    logic        exp_held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_run = 0; m_empt = 0; m_key = '0;
        exp_valid = 1'b0; exp_code = '0; exp_held = 1'b0;
    endtask

    task automatic model_frame(input logic [11:0] m);
        exp_valid = 1'b0;
        if (!m_held) begin
            if ($countones(m) == 1 && m == m_key) m_run++;
            else if ($countones(m) == 1) begin m_key = m; m_run = 1; end
            else begin m_key = '0; m_run = 0; end
            if (m_run >= DEB) begin
                exp_valid = 1'b1; exp_code = m; m_held = 1'b1;
                m_empt = 0; m_run = 0; m_key = '0;
            end
        end else begin
            if (m == '0) m_empt++;
            else m_empt = 0;
            if (m_empt >= DEB) begin m_held = 1'b0; m_empt = 0; end
        end
        exp_held = m_held;
    endtask

    task automatic do_frame(input logic [11:0] m);
        logic [2:0] ec;
        pressed = m;
        for (int i = 1; i <= 3*S; i++) begin
            @(posedge clk); #1;
            n++;
            ec = 3'b001 << ((n / S) % 3);
            chk("key_col", 32'(kif.key_col), 32'(ec));
            chk("valid", 32'(kif.valid), (i == 1) ? 32'(exp_valid) : 32'd0);
            chk("scan_data", 32'(kif.scan_data), 32'(exp_code));
            chk("key_held", 32'(kif.key_held), 32'(exp_held));
        end
        model_frame(m);
    endtask

    task automatic frames(input logic [11:0] m, input int cnt);
        for (int k = 0; k < cnt; k++) do_frame(m);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_key_col", 32'(kif.key_col), 32'h1);
        chk("rst_scan_data", 32'(kif.scan_data), 32'h0);
        chk("rst_valid", 32'(kif.valid), 32'h0);
        chk("rst_key_held", 32'(kif.key_held), 32'h0);
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_hold_key_col", 32'(kif.key_col), 32'h1);
        chk("rst_hold_valid", 32'(kif.valid), 32'h0);
        rst = 1'b1;
        n = 0;
        model_reset();
    endtask

    localparam logic [11:0] K1 = 12'h001, K2 = 12'h002, K3 = 12'h004, K5 = 12'h010,
                            K7 = 12'h040, KS = 12'h200, K0 = 12'h400, KH = 12'h800;

    initial begin
        logic [11:0] one;
        logic [11:0] mk;
        int k2;
        one = 12'h001;
        model_reset();

        // Reset with '5' held, then one accept after release of rst
        pressed = K5;
        do_reset(3);
        frames(K5, 5);
        frames('0, 4);

        // Clean '1'
        frames(K1, 10);
        frames('0, 4);

        // '#' with press bounce, then release bounce
        do_frame(KH); do_frame('0); do_frame(KH); do_frame('0);
        frames(KH, 5);
        frames('0, 2); do_frame(KH); frames('0, 4);

        // '2'+'3' together, then '2' alone
        frames(K2 | K3, 6);
        frames(K2, 4);
        frames('0, 4);

        // Rollover '*' -> '0'
        frames(KS, 4);
        frames(KS | K0, 2);
        frames(K0, 3);
        frames('0, 4);

        // Sequence 1, #, 2, *
        frames(K1, 4); frames('0, 4);
        frames(KH, 4); frames('0, 4);
        frames(K2, 4); frames('0, 4);
        frames(KS, 4); frames('0, 4);

        // Reset in the middle of a '7' press
        frames(K7, 2);
        repeat (5) @(posedge clk);
        #1;
        do_reset(2);
        frames(K7, 4);
        frames('0, 4);

        // Randomized press/bounce/multi segments
        for (int seg = 0; seg < 40; seg++) begin
            mk = one << $urandom_range(0, 11);
            k2 = $urandom_range(0, 11);
            for (int f = 0; f < int'($urandom_range(1, 5)); f++) begin
                case ($urandom_range(0, 7))
                    0:       do_frame(mk | (one << k2));
                    1:       do_frame('0);
                    default: do_frame(mk);
                endcase
            end
            for (int f = 0; f < int'($urandom_range(1, 4)); f++) begin
                if ($urandom_range(0, 5) == 0) do_frame(mk);
                else do_frame('0);
            end
        end
        frames('0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "time limit");
    end

endmodule
